// File: rtl/ram_pkg.sv
// Shared definitions for the RAM port initiator and its response buffer.
package ram_pkg;

  // Depth of the response buffer; the credit rule is built around this.
  localparam int RSP_DEPTH = 2;

  // Default data width used by clients that do not override DW.
  localparam int DW_DEF = 32;

  // One byte select per 8 data bits.
  function automatic int sel_width(input int dw);
    return dw / 8;
  endfunction

  // Response entry at the default width (read data + write-ack flag).
  typedef struct packed {
    logic [DW_DEF-1:0] dat;
    logic              is_wr;
  } rsp_ent_t;

endpackage

// File: rtl/rsp_fifo2.sv
// 2-entry synchronous FIFO with occupancy count. Same-cycle push+pop leaves
// the count unchanged and advances the head. Callers must not pop when empty
// or push into a full buffer without a simultaneous pop.
module rsp_fifo2
  import ram_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [RSP_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push_i;
    rd_ptr_d = rd_ptr_q ^ pop_i;
    count_d  = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates whether it is ever observed.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Overflow means the upstream credit accounting is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && count_q == 2'd2));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop_i && count_q == 2'd0));

endmodule

// File: rtl/ram_port_master.sv
// Initiator side of one port of the single-clock byte-select RAM.
// Turns a valid/ready request stream into the RAM's one-cycle-latency port
// and returns read data on a valid/ready response stream, buffered by a
// 2-entry FIFO so consumer backpressure never drops data.
// Optional build macro: RAM_PORT_MASTER_WR_ACK_EN -- every write also
// produces a response (rsp_is_wr=1, rsp_dat = word before the write).
module ram_port_master
  import ram_pkg::*;
#(
  parameter int DW = 32,
  parameter int SW = sel_width(DW),
  parameter int MD = 1024,
  parameter int AW = $clog2(MD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_adr,
  input  logic [SW-1:0] req_sel,
  input  logic [DW-1:0] req_dat_w,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_dat,
  output logic          rsp_is_wr,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_adr,
  output logic [SW-1:0] ram_sel,
  output logic [DW-1:0] ram_dat_w,
  input  logic [DW-1:0] ram_dat_r
);

`ifdef RAM_PORT_MASTER_WR_ACK_EN
  localparam logic WR_ACK = 1'b1;
`else
  localparam logic WR_ACK = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          is_wr;
  } rsp_t;

  logic       pend_q, pend_d;
  logic       pend_wr_q, pend_wr_d;
  logic       fire, rsp_prod, needs_credit, credit_ok;
  logic       push, pop;
  logic       is_wr_sel;
  logic [1:0] cnt;
  rsp_t       head, push_ent;

  // Credit: an access that will produce a response needs a free slot counting
  // both buffered entries and the one whose data arrives next cycle.
  always_comb begin
    needs_credit = !req_we | WR_ACK;
    credit_ok    = ({1'b0, pend_q} + cnt) < 2'd2;
    req_ready    = !rst & (credit_ok | !needs_credit);
    fire         = req_valid & req_ready;
    rsp_prod     = fire & needs_credit;
  end

  // RAM port is driven straight from the request; ram_en low holds dat_r.
  always_comb begin
    ram_en    = fire;
    ram_we    = fire & req_we;
    ram_adr   = req_adr;
    ram_sel   = req_sel;
    ram_dat_w = req_dat_w;
  end

  // Track the access whose data appears on ram_dat_r this cycle.
  always_comb begin
    pend_d    = rsp_prod;
    pend_wr_d = rsp_prod & req_we;
  end

  // Pending-access register; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= 1'b0;
      pend_wr_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Response mux: buffered head has priority (ordering); otherwise bypass
  // the RAM output directly, parking it in the FIFO if not consumed.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_dat   = '0;
    is_wr_sel = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    if (!rst) begin
      if (cnt != 2'd0) begin
        rsp_valid = 1'b1;
        rsp_dat   = head.dat;
        is_wr_sel = head.is_wr;
        pop       = rsp_ready;
        push      = pend_q;
      end else if (pend_q) begin
        rsp_valid = 1'b1;
        rsp_dat   = ram_dat_r;
        is_wr_sel = pend_wr_q;
        push      = !rsp_ready;
      end
    end
  end

  assign rsp_is_wr = WR_ACK & is_wr_sel;

  assign push_ent.dat   = ram_dat_r;
  assign push_ent.is_wr = pend_wr_q;

  rsp_fifo2 #(
    .W($bits(rsp_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_ent),
    .dout_o  (head),
    .count_o (cnt)
  );

endmodule

// File: tb/tb_ram_port_master.sv
// Directed bench for ram_port_master with a behavioural byte-select RAM.
module tb_ram_port_master;

`ifdef RAM_PORT_MASTER_WR_ACK_EN
  localparam logic WACK = 1'b1;
`else
  localparam logic WACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [9:0]  req_adr;
  logic [3:0]  req_sel;
  logic [31:0] req_dat_w;
  logic        rsp_valid, rsp_ready, rsp_is_wr;
  logic [31:0] rsp_dat;
  logic        ram_en, ram_we;
  logic [9:0]  ram_adr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_dat_w, ram_dat_r;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_port_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_sel(req_sel), .req_dat_w(req_dat_w),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_is_wr(rsp_is_wr),
    .ram_en(ram_en), .ram_we(ram_we), .ram_adr(ram_adr), .ram_sel(ram_sel),
    .ram_dat_w(ram_dat_w), .ram_dat_r(ram_dat_r)
  );

  // Behavioural RAM: registered read of the old word, byte-select write,
  // plus a backdoor preload port.
  logic [31:0] mem [1024];
  logic        pl_en;
  logic [9:0]  pl_adr;
  logic [31:0] pl_dat;

  always_ff @(posedge clk) begin
    if (pl_en) mem[pl_adr] <= pl_dat;
    if (ram_en) begin
      ram_dat_r <= mem[ram_adr];
      if (ram_we)
        for (int b = 0; b < 4; b++)
          if (ram_sel[b]) mem[ram_adr][8*b +: 8] <= ram_dat_w[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pl_adr = a; pl_dat = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [9:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        exp_rsp;
    logic [31:0] exp_dat;
    logic        exp_is_wr;
  } vec_t;

  vec_t vt[9];

  logic [31:0] got[$];
  int          got_cyc[$];
  int          fires, adr_next, issued;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b0, 10'd5, 4'b0000, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    vt[1] = '{1'b1, 10'd3, 4'b0101, 32'hAABBCCDD, WACK, 32'h11223344, WACK};
    vt[2] = '{1'b0, 10'd3, 4'b0000, 32'h0,        1'b1, 32'h11BB33DD, 1'b0};
    vt[3] = '{1'b1, 10'd9, 4'b1111, 32'hCAFEF00D, WACK, 32'h00000000, WACK};
    vt[4] = '{1'b0, 10'd9, 4'b0000, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0};
    vt[5] = '{1'b1, 10'd9, 4'b1000, 32'h12345678, WACK, 32'hCAFEF00D, WACK};
    vt[6] = '{1'b0, 10'd9, 4'b0000, 32'h0,        1'b1, 32'h12FEF00D, 1'b0};
    vt[7] = '{1'b1, 10'd2, 4'b1111, 32'h00000009, WACK, 32'h00000005, WACK};
    vt[8] = '{1'b0, 10'd2, 4'b0000, 32'h0,        1'b1, 32'h00000009, 1'b0};

    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_adr = 10'd1;
    req_sel = 4'hF; req_dat_w = 32'h0; rsp_ready = 1'b1; pl_en = 1'b0;
    pl_adr = '0; pl_dat = '0;

    // Reset state with a request already presented.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_ram_en",    32'(ram_en),    32'd0);
    chk("rst_ram_we",    32'(ram_we),    32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_dat",   rsp_dat,        32'd0);
    chk("rst_rsp_is_wr", 32'(rsp_is_wr), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    preload(10'd5, 32'hDEADBEEF);
    preload(10'd3, 32'h11223344);
    preload(10'd2, 32'h00000005);
    preload(10'd9, 32'h00000000);
    preload(10'd8, 32'h88888888);
    preload(10'd7, 32'h77777777);
    preload(10'd4, 32'h00000000);

    // Single-transaction vectors: fire, then look at the next cycle.
    for (int i = 0; i < 9; i++) begin
      req_valid = 1'b1; req_we = vt[i].we; req_adr = vt[i].adr;
      req_sel = vt[i].sel; req_dat_w = vt[i].dat;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'd1);
      chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vt[i].we));
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vt[i].exp_rsp));
      chk($sformatf("v%0d_rsp_is_wr", i), 32'(rsp_is_wr), 32'(vt[i].exp_is_wr));
      if (vt[i].exp_rsp) chk($sformatf("v%0d_rsp_dat", i), rsp_dat, vt[i].exp_dat);
      @(posedge clk); #1;
    end

    // Write then read of the same address on consecutive cycles.
    req_valid = 1'b1; req_we = 1'b1; req_adr = 10'd4; req_sel = 4'hF;
    req_dat_w = 32'hAAAA5555;
    @(posedge clk); #1;
    req_we = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("wr_rd_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rd_dat", rsp_dat, 32'hAAAA5555);
    @(posedge clk); #1;

    // Backpressure: 4 reads with rsp_ready low for the first 6 cycles.
    for (int i = 0; i < 4; i++) preload(10'(i), 32'h10 + 32'(i));
    got.delete(); fires = 0; adr_next = 0;
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      req_valid = (adr_next < 4); req_we = 1'b0; req_adr = 10'(adr_next);
      rsp_ready = (cyc >= 6);
      @(negedge clk);
      if (cyc == 5) begin
        chk("bp_fires", 32'(fires), 32'd2);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        chk("bp_head_valid", 32'(rsp_valid), 32'd1);
        chk("bp_head_dat", rsp_dat, 32'h10);
      end
      if (rsp_valid && rsp_ready) got.push_back(rsp_dat);
      if (req_valid && req_ready) begin fires++; adr_next++; end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    chk("bp_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk($sformatf("bp_rsp%0d", i), got[i], 32'h10 + 32'(i));
    @(negedge clk);
    chk("bp_no_dup", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // Streaming: 16 reads, one response per cycle.
    for (int i = 0; i < 16; i++) preload(10'(16 + i), 32'hA0000000 + 32'(i));
    got.delete(); got_cyc.delete(); issued = 0;
    for (int cyc = 0; cyc < 40 && got.size() < 16; cyc++) begin
      req_valid = (issued < 16); req_we = 1'b0; req_adr = 10'(16 + issued);
      @(negedge clk);
      if (req_valid) chk($sformatf("st_ready%0d", issued), 32'(req_ready), 32'd1);
      if (rsp_valid && rsp_ready) begin got.push_back(rsp_dat); got_cyc.push_back(cyc); end
      if (req_valid && req_ready) issued++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("st_count", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < got.size()) begin
        chk($sformatf("st_dat%0d", i), got[i], 32'hA0000000 + 32'(i));
        chk($sformatf("st_cyc%0d", i), 32'(got_cyc[i]), 32'(i + 1));
      end

    // Reset while a read is in flight.
    req_valid = 1'b1; req_we = 1'b0; req_adr = 10'd7;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rmid_valid", 32'(rsp_valid), 32'd0);
    chk("rmid_dat", rsp_dat, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rmid_stale%0d", i), 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b1; req_adr = 10'd8;
    @(negedge clk);
    chk("rmid_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rmid_rd_valid", 32'(rsp_valid), 32'd1);
    chk("rmid_rd_dat", rsp_dat, 32'h88888888);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
